// File: rtl/ysyx_22050078_div_ctrl.sv
// Multi-cycle restoring divide/remainder sequencer for RV64M div/rem (word and doubleword).
// Optional DIV_EARLY_OUT_EN: finish in the accept cycle when |dividend| < |divisor|.
module ysyx_22050078_div_ctrl #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_src1,
    input  logic [DATA_WIDTH-1:0] i_src2,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_busy
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned HW = DATA_WIDTH / 2;
    localparam logic [W-1:0]  MIN_W = {1'b1, {(W-1){1'b0}}};
    localparam logic [HW-1:0] MIN_H = {1'b1, {(HW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [W-1:0]         rem_q;
    logic [W-1:0]         quo_q;
    logic [W-1:0]         dvs_q;
    logic [W-1:0]         result_q;
    logic                 neg_quo_q;
    logic                 neg_rem_q;
    logic                 op_rem_q;
    logic                 op_word_q;
    logic                 valid_q;

    function automatic logic [W-1:0] word_ext(input logic [W-1:0] v);
        return {{HW{v[HW-1]}}, v[HW-1:0]};
    endfunction

    // Apply sign to a magnitude, then sign-extend from the word width when needed.
    function automatic logic [W-1:0] fixup(input logic [W-1:0] mag, input logic neg,
                                           input logic word);
        logic [W-1:0] v;
        v = neg ? ('0 - mag) : mag;
        return word ? word_ext(v) : v;
    endfunction

    // Operand preparation at the selected width.
    logic         op_uns;
    logic         op_rem;
    logic         op_word;
    logic [W-1:0] a_ext;
    logic [W-1:0] b_ext;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    logic [W-1:0] a_fin;
    logic         a_neg;
    logic         b_neg;
    logic         b_zero;
    logic         ovf;
    logic         early;
    logic         special;
    logic [W-1:0] special_res;

    assign op_uns  = i_op[0];
    assign op_rem  = i_op[1];
    assign op_word = i_op[2];

    always_comb begin
        a_ext = i_src1;
        b_ext = i_src2;
        if (op_word) begin
            a_ext = op_uns ? {{HW{1'b0}}, i_src1[HW-1:0]} : {{HW{i_src1[HW-1]}}, i_src1[HW-1:0]};
            b_ext = op_uns ? {{HW{1'b0}}, i_src2[HW-1:0]} : {{HW{i_src2[HW-1]}}, i_src2[HW-1:0]};
        end
    end

    assign a_neg  = ~op_uns & a_ext[W-1];
    assign b_neg  = ~op_uns & b_ext[W-1];
    assign a_mag  = a_neg ? ('0 - a_ext) : a_ext;
    assign b_mag  = b_neg ? ('0 - b_ext) : b_ext;
    assign a_fin  = op_word ? word_ext(a_ext) : a_ext;
    assign b_zero = (b_ext == '0);
    assign ovf    = ~op_uns & (b_ext == '1) &
                    (op_word ? (a_ext[HW-1:0] == MIN_H) : (a_ext == MIN_W));

`ifdef DIV_EARLY_OUT_EN
    assign early = ~b_zero & (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    assign special = b_zero | ovf | early;

    always_comb begin
        if (b_zero) begin
            special_res = op_rem ? a_fin : '1;
        end else if (ovf) begin
            special_res = op_rem ? '0 : a_fin;
        end else begin
            special_res = op_rem ? a_fin : '0;
        end
    end

    // One restoring step: shift {rem, quo}, trial-subtract the divisor magnitude.
    logic [W:0]   shift_rem;
    logic         fits;
    logic [W:0]   trial;
    logic [W-1:0] step_rem;
    logic [W-1:0] step_quo;

    assign shift_rem = {rem_q, quo_q[W-1]};
    assign fits      = (shift_rem >= {1'b0, dvs_q});
    assign trial     = fits ? (shift_rem - {1'b0, dvs_q}) : shift_rem;
    assign step_rem  = trial[W-1:0];
    assign step_quo  = {quo_q[W-2:0], fits};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            op_rem_q  <= 1'b0;
            op_word_q <= 1'b0;
            valid_q   <= 1'b0;
        end else if (i_flush) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        op_rem_q  <= op_rem;
                        op_word_q <= op_word;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        dvs_q     <= b_mag;
                        if (special) begin
                            state_q  <= DONE;
                            valid_q  <= 1'b1;
                            result_q <= special_res;
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= op_word ? CNT_WIDTH'(HW) : CNT_WIDTH'(W);
                            rem_q   <= '0;
                            // Word dividends start in the upper half so the MSB shifts out first.
                            quo_q   <= op_word ? {a_mag[HW-1:0], {HW{1'b0}}} : a_mag;
                        end
                    end
                end
                CALC: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt_q <= cnt_q - CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        state_q  <= DONE;
                        valid_q  <= 1'b1;
                        result_q <= op_rem_q ? fixup(step_rem, neg_rem_q, op_word_q)
                                             : fixup(step_quo, neg_quo_q, op_word_q);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state_q  <= IDLE;
                        valid_q  <= 1'b0;
                        result_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_busy   = (i_valid & o_ready & ~i_flush) | (state_q == CALC) |
                      ((state_q == DONE) & ~i_ready);

endmodule
